// File: rtl/rx_pkt_fifo_pkg.sv
// rx_pkt_fifo_pkg
// Shared types and helpers for the receive packet FIFO.
//   wr_state_e   : write-side frame FSM states
//   entry_width(): width of one packed memory entry {tuser?, last, keep, data}
//   rx_entry_t   : entry layout at the default 32-bit data width
// Optional feature macro: RX_PKT_FIFO_ERR_FWD_EN adds a per-entry error bit
// so errored frames are forwarded (tagged) instead of dropped.
package rx_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    DROP
  } wr_state_e;

`ifdef RX_PKT_FIFO_ERR_FWD_EN
  localparam int TUSER_W = 1;
`else
  localparam int TUSER_W = 0;
`endif

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = DEF_DATA_W / 8;

  // One entry holds data, keep, the last flag and (optionally) the error tag.
  function automatic int entry_width(input int data_w, input int ctrl_w);
    return data_w + ctrl_w + 1 + TUSER_W;
  endfunction

  typedef struct packed {
`ifdef RX_PKT_FIFO_ERR_FWD_EN
    logic                  err;
`endif
    logic                  last;
    logic [DEF_CTRL_W-1:0] keep;
    logic [DEF_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_axis_pkt_fifo_sdp_ram.sv
// sdp_ram
// Simple dual-port RAM, single clock, registered read with enable so the
// read register holds its value while the consumer side is stalled.
//   clk     : clock
//   wr_en   : write strobe for wr_addr/wr_data
//   rd_en   : load rd_data from rd_addr on this edge
//   rd_data : registered read data
module sdp_ram #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 37
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // No reset on the array or read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_axis_pkt_fifo.sv
// rx_axis_pkt_fifo
// Store-and-forward RX packet FIFO between the MAC beat stream and an
// AXI-Stream consumer. Frames are written speculatively and only become
// visible to the reader once committed; errored or overflowing frames are
// rolled back by rewinding the speculative write pointer.
// Ports:
//   i_rx_clk / i_rx_reset_n         : clock, async active-low reset
//   i_data/_keep/_valid/_err        : unthrottled MAC beat stream
//   m_axis_tdata/tkeep/tvalid/tlast : AXI-Stream master, m_axis_trdy ready
//   m_axis_tuser                    : error tag on last beat (feature only)
//   o_frame_drop / o_overflow       : one-cycle drop / overflow pulses
// Optional feature macro: RX_PKT_FIFO_ERR_FWD_EN (forward errored frames).
module rx_axis_pkt_fifo
  import rx_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int DEPTH      = 512
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_data_keep,
  input  logic                  i_data_valid,
  input  logic                  i_data_err,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
`ifdef RX_PKT_FIFO_ERR_FWD_EN
  output logic                  m_axis_tuser,
`endif
  input  logic                  m_axis_trdy,
  output logic                  o_frame_drop,
  output logic                  o_overflow
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = entry_width(DATA_WIDTH, CTRL_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  wr_state_e             state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic [CTRL_WIDTH-1:0] stage_keep_q, stage_keep_d;
  logic                  err_acc_q, err_acc_d;
  logic                  drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic                  ram_vld_q, ram_vld_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CTRL_WIDTH-1:0] tkeep_q, tkeep_d;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
  logic                  tuser_q, tuser_d;
  logic                  wr_err;
`endif

  logic               full;
  logic               err_final;
  logic               out_ready;
  logic               ram_we;
  logic               ram_rd_en;
  logic               wr_last;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  // Full is judged against the pre-edge read pointer, so a simultaneous
  // read at full still counts as overflow.
  assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign err_final = err_acc_q | i_data_err;
  assign out_ready = !tvalid_q || m_axis_trdy;

`ifdef RX_PKT_FIFO_ERR_FWD_EN
  assign ram_wdata = {wr_err, wr_last, stage_keep_q, stage_data_q};
`else
  assign ram_wdata = {wr_last, stage_keep_q, stage_data_q};
`endif

  // Write side: the stage register delays the stream by one beat so the
  // entry carrying last=1 is known exactly when valid drops.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    stage_data_d = stage_data_q;
    stage_keep_d = stage_keep_q;
    err_acc_d    = err_acc_q;
    drop_d       = 1'b0;
    ovf_d        = 1'b0;
    ram_we       = 1'b0;
    wr_last      = 1'b0;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
    wr_err       = 1'b0;
`endif
    case (state_q)
      WAIT_IDLE: begin
        if (!i_data_valid) state_d = IDLE;
      end
      IDLE: begin
        if (i_data_valid) begin
          stage_data_d = i_data;
          stage_keep_d = i_data_keep;
          err_acc_d    = i_data_err;
          state_d      = RECV;
        end
      end
      RECV: begin
        if (full) begin
          state_d  = DROP;
          wr_ptr_d = wr_commit_q;
          drop_d   = 1'b1;
          ovf_d    = 1'b1;
        end else if (i_data_valid) begin
          ram_we       = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          stage_data_d = i_data;
          stage_keep_d = i_data_keep;
          err_acc_d    = err_final;
        end else begin
          state_d = IDLE;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
          ram_we      = 1'b1;
          wr_last     = 1'b1;
          wr_err      = err_final;
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          wr_commit_d = wr_ptr_q + PTR_ONE;
`else
          if (err_final) begin
            wr_ptr_d = wr_commit_q;
            drop_d   = 1'b1;
          end else begin
            ram_we      = 1'b1;
            wr_last     = 1'b1;
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            wr_commit_d = wr_ptr_q + PTR_ONE;
          end
`endif
        end
      end
      DROP: begin
        if (!i_data_valid) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Read side: two-stage pipeline (RAM read register, then output register).
  // A new RAM read is issued whenever the RAM register is empty or will be
  // drained into the output register this cycle.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
    tuser_d   = tuser_q;
`endif
    ram_rd_en = (!ram_vld_q || out_ready) && (rd_ptr_q != wr_commit_q);
    ram_vld_d = ram_rd_en || (ram_vld_q && !out_ready);
    if (ram_rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (out_ready) begin
      tvalid_d = ram_vld_q;
      if (ram_vld_q) begin
        tdata_d = ram_rdata[DATA_WIDTH-1:0];
        tkeep_d = ram_rdata[DATA_WIDTH +: CTRL_WIDTH];
        tlast_d = ram_rdata[DATA_WIDTH+CTRL_WIDTH];
`ifdef RX_PKT_FIFO_ERR_FWD_EN
        tuser_d = ram_rdata[DATA_WIDTH+CTRL_WIDTH+1];
`endif
      end else begin
        tlast_d = 1'b0;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
        tuser_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      state_q      <= WAIT_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      stage_data_q <= '0;
      stage_keep_q <= '0;
      err_acc_q    <= 1'b0;
      drop_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ram_vld_q    <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
      tuser_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      stage_data_q <= stage_data_d;
      stage_keep_q <= stage_keep_d;
      err_acc_q    <= err_acc_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      ram_vld_q    <= ram_vld_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
      tuser_q      <= tuser_d;
`endif
    end
  end

  sdp_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .clk     (i_rx_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
`ifdef RX_PKT_FIFO_ERR_FWD_EN
  assign m_axis_tuser  = tuser_q;
`endif
  assign o_frame_drop  = drop_q;
  assign o_overflow    = ovf_q;

endmodule

// File: doc/rx_axis_pkt_fifo.md
# rx_axis_pkt_fifo

Store-and-forward receive packet FIFO sitting directly downstream of the Ethernet MAC/PCS top-level RX output in the `i_rx_clk` domain. It accepts the MAC's unthrottled `o_data`/`o_data_keep`/`o_data_valid`/`o_data_err` beat stream, delimits frames, and buffers each whole frame before release. It presents committed frames on an AXI-Stream master with `tlast` and backpressure. Errored or overflowing frames are rolled back and never reach the consumer.

## Interface
- `DATA_WIDTH`, default 32: data beat width; must equal MAC data width.
- `CTRL_WIDTH`, default 4: keep width, `DATA_WIDTH/8`.
- `DEPTH`, default 512: FIFO entries, power of two, at least 64.
- `i_rx_clk`, in, 1: the only clock.
- `i_rx_reset_n`, in, 1: reset, asynchronous assert, active-low.
- `i_data`, in, `DATA_WIDTH`: MAC RX data.
- `i_data_keep`, in, `CTRL_WIDTH`: byte enables. All-ones except on the final beat.
- `i_data_valid`, in, 1: beat valid. A frame is one contiguous run of valid cycles.
- `i_data_err`, in, 1: frame error, sampled on any beat or in the first invalid cycle after the run.
- `m_axis_tdata`, out, `DATA_WIDTH`: output data.
- `m_axis_tkeep`, out, `CTRL_WIDTH`: output keep.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tlast`, out, 1: last beat of frame.
- `m_axis_trdy`, in, 1: consumer ready.
- `o_frame_drop`, out, 1: one-cycle pulse per dropped frame.
- `o_overflow`, out, 1: one-cycle pulse when a frame is dropped because the FIFO filled.

## Operation
- Memory entry holds {last, keep, data}.
- Pointers:
  - `wr_ptr`: speculative write pointer.
  - `wr_commit`: committed write pointer.
  - `rd_ptr`: read pointer.
  - All are `$clog2(DEPTH)+1` bits, so they wrap naturally. Full when `wr_ptr - rd_ptr == DEPTH`; empty when `rd_ptr == wr_commit`.
- Input stage register holds the most recent beat. It is written to memory when the next beat arrives (last=0) or when `i_data_valid` falls (last=1). This gives a one-beat delay, so `tlast` is exact.
- Write FSM:
  - WAIT_IDLE: entered on reset. Ignores input until `i_data_valid`=0, then goes to IDLE. This prevents capturing a partial frame.
  - IDLE: `i_data_valid`=1 latches the beat into the stage, clears the error accumulator, goes to RECV.
  - RECV:
    - Each valid beat writes the previous stage entry and ORs `i_data_err` into the accumulator.
    - On the first invalid cycle, write the stage with last=1 and OR `i_data_err`.
    - Accumulator clear: set `wr_commit <= wr_ptr+1`.
    - Accumulator set: set `wr_ptr <= wr_commit` and pulse `o_frame_drop`.
    - Either way, go to IDLE.
  - DROP: entered from RECV when a write is needed while full.
    - On entry, set `wr_ptr <= wr_commit` and pulse `o_frame_drop` and `o_overflow` in the same cycle.
    - Discard beats until `i_data_valid`=0, then go to IDLE.
- Back-to-back frames need at least one invalid cycle between them (MAC guarantees IFG). The cycle that closes a frame is never also the first beat of the next.
- Read side: first-word-fall-through with a registered output stage.
  - An entry transfers on `m_axis_tvalid && m_axis_trdy`.
  - The output register refills in the same cycle if committed data exists.
  - Sustained throughput is one beat per cycle.
- Only committed entries are ever read. Rollback never disturbs the read side.
- Zero-length frames cannot occur. Frames of one beat are legal and produce a single beat with last=1.

## Timing
- Reset values: all pointers 0, FSM=WAIT_IDLE, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`/`m_axis_tkeep`=0, `o_frame_drop`=0, `o_overflow`=0.
- Let `i_data_valid` first sample 0 at edge N after a frame:
  - commit occurs at edge N;
  - with the FIFO empty, `m_axis_tvalid`=1 after edge N+2.
- `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` are held stable while `m_axis_tvalid && !m_axis_trdy`.
- `o_frame_drop` and `o_overflow` are registered and asserted for exactly one cycle, the cycle after edge N (or after DROP entry).
- Simultaneous read and write at full: the full check uses the pre-edge `rd_ptr`, so the write still counts as an overflow (conservative).
- Reset mid-frame clears all buffered data, including committed data.

## Configuration
- `RX_PKT_FIFO_ERR_FWD_EN`, defined:
  - Errored frames are committed, not dropped.
  - An extra output `m_axis_tuser` (1 bit, reset 0) equals the error flag on the last beat and is 0 elsewhere; the memory entry gains one bit.
  - `o_frame_drop` pulses only on overflow.
- Undefined: errored frames are dropped as above and `m_axis_tuser` does not exist.

## Structure
- Package `rx_pkt_fifo_pkg`: write-FSM state enum (WAIT_IDLE, IDLE, RECV, DROP), and the entry struct typedef parameterised by widths via localparam helpers.
- Sub-module `sdp_ram`: simple dual-port RAM, one clock, registered read, inferable as block RAM; instantiated once.

## Test plan
- Single 64-byte frame (16 beats, last keep 4'hF), `m_axis_trdy`=1: 16 output beats, `tlast` only on beat 16, first `tvalid` 2 cycles after the commit edge.
- Frame with `i_data_err`=1 in the cycle after the last beat: no output, `o_frame_drop` pulses once, `o_overflow`=0. The following good frame is output intact.
- `DEPTH`=64, `m_axis_trdy`=0, 100-beat frame: `o_overflow` and `o_frame_drop` pulse on beat 65. After a subsequent good 8-beat frame and `trdy`=1, exactly 8 beats are output.
- Two frames of 5 and 1 beat (last keep 4'h3) separated by one idle cycle, with random `trdy` toggling: exact data/keep/last sequence and stable data while stalled.
- Reset asserted mid-frame, released while `i_data_valid`=1: the remainder of that frame is ignored (WAIT_IDLE) and the next full frame is output correctly.
- With `RX_PKT_FIFO_ERR_FWD_EN`: errored 3-beat frame is output with `tuser`=1 on beat 3 only, and `o_frame_drop` stays 0.
